sm_seq_ctrl: RTL and testbench
==============================

SM_SEQ_CTRL -- requirements
Module: sm_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of sequential stages (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_W, default 8, width of the per-stage timeout counter and limit.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a sequence; sampled only in IDLE.
REQ-006 SHALL have port step  input  NUM_STAGES  step[k] is the advance condition for stage k.
REQ-007 SHALL have port abort  input  1  return to IDLE from any stage.
REQ-008 SHALL have port timeout_limit  input  TIMEOUT_W  cycles allowed per stage; 0 disables timeout.
REQ-009 SHALL have port control  output  NUM_STAGES  one-hot; control[k]=1 while in stage k.
REQ-010 SHALL have port stage_idx  output  ceil(log2(NUM_STAGES))  index of the current stage; 0 when not in a stage.
REQ-011 SHALL have port busy  output  1  high in any stage or DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on sequence completion.
REQ-013 SHALL have port fault  output  1  one-cycle pulse on stage timeout.
REQ-014 SHALL have port fault_stage  output  ceil(log2(NUM_STAGES))  stage that timed out; held until the next accepted start.

Function
REQ-015 SHALL implement states IDLE, STAGE_0..STAGE_(NUM_STAGES-1), DONE; all outputs registered (Moore).
REQ-016 IDLE: start=1 at an edge -> STAGE_0 after that edge (control[0]=1 one cycle after start is sampled).
REQ-017 STAGE_k priority per edge: abort > step[k] > timeout > stay.
REQ-018 STAGE_k, abort=1 -> IDLE; no done and no fault pulse.
REQ-019 STAGE_k, step[k]=1, k<NUM_STAGES-1 -> STAGE_(k+1); k=NUM_STAGES-1 -> DONE.
REQ-020 step[j] for j!=current stage SHALL be ignored; start SHALL be ignored outside IDLE.
REQ-021 DONE SHALL last exactly one cycle with done=1, busy=1, control=0, then go to IDLE unconditionally.
REQ-022 Stage counter SHALL be 0 on the first cycle of every stage entry and increment each cycle in the stage, saturating at all-ones.
REQ-023 Timeout: in STAGE_k with timeout_limit!=0, counter==timeout_limit-1, step[k]=0, abort=0 -> IDLE; fault=1 and fault_stage=k on the first IDLE cycle.
REQ-024 Step and timeout on the same edge SHALL advance (step wins); abort and timeout on the same edge SHALL give no fault.
REQ-025 timeout_limit SHALL be sampled every cycle; changing it mid-stage takes effect immediately against the current count.
REQ-026 An accepted start SHALL clear fault_stage to 0.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, counter=0, control=0, stage_idx=0, busy=0, done=0, fault=0, fault_stage=0, overriding every other input.
REQ-028 Reset asserted mid-sequence SHALL abandon it with no done or fault pulse; start on the first edge after reset deasserts SHALL be accepted.

Configuration
REQ-029 Macro SM_SEQ_TIMEOUT_EN defined: timeout counter and fault logic SHALL be compiled in per REQ-022..REQ-026.
REQ-030 SM_SEQ_TIMEOUT_EN undefined: no counter SHALL be built, timeout_limit SHALL remain a port but be ignored, fault and fault_stage SHALL be constant 0, stages wait indefinitely.

Verification
REQ-031 NUM_STAGES=3, limit=4: reset 2 cycles, start pulse, step[0], step[1], step[2] each 2 cycles apart -> control 001,010,100, one-cycle done, busy=0 next cycle, fault never set.
REQ-032 limit=4: start, step[0], then no step in STAGE_1 -> exits after 4 cycles in STAGE_1, fault one-cycle pulse, fault_stage=1, control=000.
REQ-033 In STAGE_2 assert abort and step[2] on the same edge -> IDLE, done stays 0, fault stays 0.
REQ-034 In STAGE_0 assert step[1], step[2] and start for 3 cycles -> remains STAGE_0, control=001, stage_idx=0.
REQ-035 Reset asserted for one edge while in STAGE_1 -> all outputs 0 next cycle; start on the following edge -> control=001.
REQ-036 limit=0 (or macro undefined, any limit), start then no steps for 300 cycles -> stays STAGE_0, fault never asserts.

Source files
------------

// File: rtl/sm_seq_ctrl.sv
// Sequential stage controller: IDLE -> STAGE_0..STAGE_(N-1) -> DONE, one-hot stage control.
// Define SM_SEQ_TIMEOUT_EN to build the per-stage timeout counter and fault reporting.
module sm_seq_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int TIMEOUT_W  = 8,
  localparam int SW        = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] step,
  input  logic                  abort,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  output logic [NUM_STAGES-1:0] control,
  output logic [SW-1:0]         stage_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  fault,
  output logic [SW-1:0]         fault_stage
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STAGE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic            step_cur;
  logic            timeout_take;

  assign step_cur = step[cur_q];

`ifdef SM_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] limit_m1;
  logic                 fault_q;
  logic [SW-1:0]        fault_stage_q;

  assign limit_m1     = timeout_limit - {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  // Timeout only fires when neither abort nor the current step claims the edge.
  assign timeout_take = (state_q == S_STAGE) && !abort && !step_cur &&
                        (timeout_limit != '0) && (cnt_q == limit_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q != S_STAGE || state_d != S_STAGE || cur_d != cur_q) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      fault_q <= timeout_take;
      if (timeout_take) begin
        fault_stage_q <= cur_q;
      end else if (state_q == S_IDLE && start) begin
        fault_stage_q <= '0;
      end
    end
  end

  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;
`else
  logic unused_limit;

  assign unused_limit = ^timeout_limit;
  assign timeout_take = 1'b0;
  assign fault        = 1'b0;
  assign fault_stage  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STAGE;
          cur_d   = '0;
        end
      end
      S_STAGE: begin
        if (abort || timeout_take) begin
          state_d = S_IDLE;
          cur_d   = '0;
        end else if (step_cur) begin
          if (cur_q == LAST_STAGE) begin
            state_d = S_DONE;
            cur_d   = '0;
          end else begin
            cur_d = cur_q + SW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cur_d   = '0;
      end
    endcase
  end

  always_comb begin
    control   = '0;
    stage_idx = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_STAGE: begin
        control   = NUM_STAGES'(1) << cur_q;
        stage_idx = cur_q;
        busy      = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sm_seq_ctrl.sv
// Bench for sm_seq_ctrl: directed scenarios plus randomized traffic against a stage-position model.
module tb_sm_seq_ctrl;
  localparam int N  = 3;
  localparam int TW = 8;
  localparam int SW = 2;
  localparam int OW = N + SW + 3 + SW;
`ifdef SM_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [N-1:0]  step;
  logic [TW-1:0] timeout_limit;
  logic [N-1:0]  control;
  logic [SW-1:0] stage_idx, fault_stage;
  logic          busy, done, fault;

  int errors = 0;
  int checks = 0;

  // Model: position -1 = idle, 0..N-1 = stage, N = done; cnt = cycles spent in stage.
  int m_pos = -1;
  int m_cnt = 0;
  bit m_fault = 1'b0;
  int m_fs = 0;

  logic [OW-1:0] exp_q[$];

  sm_seq_ctrl #(.NUM_STAGES(N), .TIMEOUT_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .step(step), .abort(abort),
    .timeout_limit(timeout_limit), .control(control), .stage_idx(stage_idx),
    .busy(busy), .done(done), .fault(fault), .fault_stage(fault_stage)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] dut_vec();
    return {control, stage_idx, busy, done, fault, fault_stage};
  endfunction

  function automatic logic [OW-1:0] model_vec();
    logic [N-1:0]  c;
    logic [SW-1:0] idx;
    c   = '0;
    idx = '0;
    if (m_pos >= 0 && m_pos < N) begin
      c[m_pos] = 1'b1;
      idx      = SW'(m_pos);
    end
    return {c, idx, (m_pos >= 0), (m_pos == N), m_fault, SW'(m_fs)};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_pos = -1; m_cnt = 0; m_fault = 1'b0; m_fs = 0;
    end else begin
      m_fault = 1'b0;
      if (m_pos < 0) begin
        if (start) begin m_pos = 0; m_cnt = 0; m_fs = 0; end
      end else if (m_pos == N) begin
        m_pos = -1;
      end else if (abort) begin
        m_pos = -1;
      end else if (step[m_pos]) begin
        m_pos = m_pos + 1; m_cnt = 0;
      end else if (TO_EN && timeout_limit != 0 && m_cnt == int'(timeout_limit) - 1) begin
        m_fault = 1'b1; m_fs = m_pos; m_pos = -1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; step = '0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", dut_vec(), {OW{1'b0}});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_idle: got %b expected %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_full_sequence();
    logic [N-1:0] exp_ctrl;
    bit fault_seen;
    fault_seen = 1'b0;
    timeout_limit = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_ctrl = '0;
      exp_ctrl[k] = 1'b1;
      checks++;
      if (control !== exp_ctrl || stage_idx !== SW'(k) || busy !== 1'b1) begin
        errors++; $display("FAIL seq_stage%0d: got ctrl=%b idx=%0d busy=%b expected ctrl=%b idx=%0d busy=1",
                            k, control, stage_idx, busy, exp_ctrl, k);
      end
      fault_seen |= fault;
      tick();
      fault_seen |= fault;
      step = '0;
      step[k] = 1'b1;
      tick();
      step = '0;
    end
    checks++;
    if (control !== 3'b000 || done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL seq_done: got ctrl=%b done=%b busy=%b expected ctrl=000 done=1 busy=1", control, done, busy);
    end
    fault_seen |= fault;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL seq_after_done: got %b expected %b", dut_vec(), model_vec());
    end
    checks++;
    if (fault_seen) begin
      errors++; $display("FAIL seq_fault: got fault seen=1 expected 0");
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] exp_ctrl;
    timeout_limit = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    step = 3'b001;
    tick();
    step = '0;
    for (int i = 0; i < 4; i++) tick();
    exp_ctrl = TO_EN ? 3'b000 : 3'b010;
    checks++;
    if (control !== exp_ctrl || fault !== TO_EN || fault_stage !== (TO_EN ? 2'd1 : 2'd0)) begin
      errors++; $display("FAIL timeout_exit: got ctrl=%b fault=%b fstage=%0d expected ctrl=%b fault=%b fstage=%0d",
                          control, fault, fault_stage, exp_ctrl, TO_EN, TO_EN ? 1 : 0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_stage !== (TO_EN ? 2'd1 : 2'd0) || control !== 3'b000) begin
      errors++; $display("FAIL timeout_hold: got fault=%b fstage=%0d ctrl=%b expected fault=0 fstage=%0d ctrl=000",
                          fault, fault_stage, control, TO_EN ? 1 : 0);
    end
    // Accepted start clears the recorded stage; then shrink the limit mid-stage.
    timeout_limit = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (fault_stage !== 2'd0 || control !== 3'b001) begin
      errors++; $display("FAIL timeout_clear: got fstage=%0d ctrl=%b expected fstage=0 ctrl=001", fault_stage, control);
    end
    tick();
    tick();
    timeout_limit = 8'd3;
    tick();
    checks++;
    if (dut_vec() !== model_vec() || fault !== TO_EN) begin
      errors++; $display("FAIL timeout_limit_change: got %b expected %b", dut_vec(), model_vec());
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort_step();
    timeout_limit = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    step = 3'b001;
    tick();
    step = 3'b010;
    tick();
    abort = 1'b1;
    step = 3'b100;
    tick();
    abort = 1'b0;
    step = '0;
    checks++;
    if (control !== 3'b000 || done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL abort_step: got %b expected %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_ignore_foreign();
    timeout_limit = 8'd0;
    start = 1'b1;
    tick();
    step = 3'b110;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (control !== 3'b001 || stage_idx !== 2'd0) begin
        errors++; $display("FAIL ignore_foreign_%0d: got ctrl=%b idx=%0d expected ctrl=001 idx=0", i, control, stage_idx);
      end
    end
    idle_inputs();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    timeout_limit = 8'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    step = 3'b001;
    tick();
    step = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_mid: got %b expected %b", dut_vec(), {OW{1'b0}});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (control !== 3'b001 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_restart: got ctrl=%b busy=%b expected ctrl=001 busy=1", control, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_no_timeout();
    bit fault_seen;
    fault_seen = 1'b0;
    timeout_limit = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      fault_seen |= fault;
    end
    checks++;
    if (control !== 3'b001 || fault_seen) begin
      errors++; $display("FAIL no_timeout: got ctrl=%b fault_seen=%b expected ctrl=001 fault_seen=0", control, fault_seen);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_v;
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
      for (int b = 0; b < N; b++) step[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) timeout_limit = TW'($urandom_range(0, 6));
      tick();
      exp_q.push_back(model_vec());
      exp_v = exp_q.pop_front();
      checks++;
      if (dut_vec() !== exp_v) begin
        errors++; $display("FAIL random_cycle%0d: got %b expected %b", i, dut_vec(), exp_v);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    timeout_limit = 8'd4;
    test_reset();
    test_full_sequence();
    test_timeout();
    test_abort_step();
    test_ignore_foreign();
    test_reset_mid();
    test_no_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
